add_pipe: RTL and testbench
===========================

# add_pipe

Parametrised, pipelined integer adder/subtractor with valid/ready handshakes. It is the multi-cycle successor to the single-cycle 32-bit adder in the MIPS datapath, generalised in width, carry-chain pipelining, add/sub mode and flags. Intended users are the multi-cycle ALU path and the wide-word (multi-precision) arithmetic unit. Throughput is one operation per cycle, latency is `STAGES` cycles, and the pipeline stalls globally under output backpressure.

## Interface
- `WIDTH`, 32: operand and result width; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth and carry-chain segments; chunk width `CW = WIDTH/STAGES`; 1 ≤ `STAGES` ≤ `WIDTH`.
- `TAG_W`, 4: width of the opaque tag carried alongside each operation.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted when `in_valid && in_ready` at a rising edge.
- `a`, `b`  in  `WIDTH`  operands, two's-complement or unsigned.
- `carry_in`  in  1  carry-in (add) / borrow-in (sub).
- `sub`  in  1  0: add, 1: subtract.
- `tag_in`  in  `TAG_W`  user tag.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `sum`  out  `WIDTH`  result.
- `carry_out`  out  1  raw carry out of the MSB.
- `overflow`  out  1  signed overflow.
- `zero`  out  1  `sum == 0`; evaluated after saturation.
- `tag_out`  out  `TAG_W`  tag of the result.

## Operation
- Effective operand is `bx = sub ? ~b : b`. Effective carry-in is `cin = sub ? ~carry_in : carry_in`. For subtract, `carry_in` = 1 means borrow.
- Result is `{carry_out, sum} = a + bx + cin`, computed modulo 2^`WIDTH`. `carry_out` is the raw carry; for subtract, 1 means no borrow.
- Stage `i` (0 ≤ `i` < `STAGES`) adds chunk `i` (bits `i*CW +: CW`) with the carry registered by stage `i-1`. Stage 0 uses `cin`.
- Unprocessed upper chunks of `a`/`bx` travel with the operation. Completed lower sum chunks, `tag` and `valid` also travel with it, one register level per stage.
- `overflow = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB])`, computed in the last stage from the pre-saturation sum.
- Stall rule: `adv = !out_valid || out_ready`. When `adv` = 0, all stage registers hold, including bubbles. When `adv` = 1, every stage shifts by one.
- `in_ready = adv`, combinational from `out_ready` and `out_valid`. When `in_ready` = 1 and `in_valid` = 0, a bubble enters stage 0.
- Bubbles are not collapsed during a stall.
- Reset state: all valid bits, data, carries and tags are 0. Outputs after reset: `out_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0, `zero`=0, `tag_out`=0, `in_ready`=1.
- Reset asserted mid-operation discards all in-flight operations immediately (asynchronous). No partial result is ever presented.
- Inputs are sampled only on accept. Changes to `a`/`b`/`sub` while not accepted have no effect.

## Timing
- Latency: an operation accepted at edge k gives `out_valid`=1 after edge k+`STAGES`, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while `out_ready`=1.
- All outputs are registered except `in_ready`.
- `STAGES`=1 degenerates to a registered single-cycle adder with latency 1.
- Results exit in acceptance order. No operation is dropped or duplicated under any `out_ready` pattern.
- Simultaneous output handshake and input accept in the same cycle is legal and required for full throughput.

## Configuration
- `ADD_PIPE_SAT_EN` defined: when `overflow`=1, the last stage replaces `sum` with signed saturation.
  - Result is 0x7FF…F if `a[MSB]`=0, else 0x800…0.
  - `overflow` still reports 1. `carry_out` is unaffected. Latency is unchanged.
- `ADD_PIPE_SAT_EN` undefined: `sum` wraps modulo 2^`WIDTH`. No saturation logic is present.

## Test plan
- `WIDTH`=32, `STAGES`=4, add, `a`=0x7FFFFFFF, `b`=1, `carry_in`=0 -> `sum`=0x80000000, `carry_out`=0, `overflow`=1, 4 cycles after accept. With `ADD_PIPE_SAT_EN`: `sum`=0x7FFFFFFF.
- Add, `a`=0xFFFFFFFF, `b`=0x80000000, `carry_in`=0 -> `sum`=0x7FFFFFFF, `carry_out`=1, `overflow`=1. With `ADD_PIPE_SAT_EN`: `sum`=0x80000000.
- Sub, `a`=5, `b`=7, `carry_in`=0 -> `sum`=0xFFFFFFFE, `carry_out`=0, `overflow`=0, `zero`=0. Sub, `a`=`b`=0x1234 -> `sum`=0, `carry_out`=1, `zero`=1.
- Stream 8 back-to-back ops with tags 0–7 while `out_ready` toggles 1,0,0,1,… -> all 8 results arrive in tag order with correct sums. `in_ready` mirrors `adv` every cycle. No duplicates are presented.
- Carry ripple across all chunks: `a`=0xFFFFFFFF, `b`=0, `carry_in`=1 -> `sum`=0, `carry_out`=1, `zero`=1. Repeat with `STAGES`=1 and `STAGES`=32 and confirm latencies of 1 and 32.
- Assert `rst_n`=0 with 3 ops in flight -> `out_valid` drops to 0 immediately and all outputs become 0. After release, `in_ready`=1 and the first new op returns after exactly `STAGES` cycles.

Source files
------------

// File: rtl/add_pipe_if.sv
// Handshake/data bundle for add_pipe: operation request side and result side.
// master drives operations and consumes results; slave is the adder pipeline.
interface add_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, carry_in, sub, tag_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero, tag_out
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, tag_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero, tag_out
  );
endinterface

// File: rtl/add_pipe.sv
// Pipelined add/sub with a carry chain split into STAGES chunks and global stall.
// Define ADD_PIPE_SAT_EN to saturate the sum to the signed range on overflow.
module add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  add_pipe_if.slave   bus
);
  localparam int CW  = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  logic             adv;
  logic [WIDTH-1:0] in_bx;
  logic             in_cin;

  // Level j holds an operation whose chunks below j are already summed.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] bx_q    [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];

  logic [CW:0]      chunk_res [STAGES];
  logic [WIDTH-1:0] stage_sum [STAGES];

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             zero_r;
  logic [TAG_W-1:0] tag_out_r;

  logic [WIDTH-1:0] full_sum;
  logic [WIDTH-1:0] res_sum;
  logic             raw_cout;
  logic             a_msb;
  logic             ovf;

  function automatic logic [WIDTH-1:0] put_chunk(
    input logic [WIDTH-1:0] v,
    input logic [CW-1:0]    c,
    input int               idx
  );
    put_chunk = v;
    put_chunk[idx*CW +: CW] = c;
  endfunction

  assign adv          = !out_valid_r || bus.out_ready;
  assign bus.in_ready = adv;
  assign in_bx        = bus.sub ? ~bus.b : bus.b;
  assign in_cin       = bus.sub ? ~bus.carry_in : bus.carry_in;

  for (genvar j = 0; j < STAGES; j++) begin : g_chunk
    assign chunk_res[j] = {1'b0, a_q[j][j*CW +: CW]}
                        + {1'b0, bx_q[j][j*CW +: CW]}
                        + {{CW{1'b0}}, carry_q[j]};
    assign stage_sum[j] = put_chunk(sum_q[j], chunk_res[j][CW-1:0], j);
  end

  assign full_sum = stage_sum[STAGES-1];
  assign raw_cout = chunk_res[STAGES-1][CW];
  assign a_msb    = a_q[STAGES-1][MSB];
  assign ovf      = (a_msb == bx_q[STAGES-1][MSB]) && (full_sum[MSB] != a_msb);

`ifdef ADD_PIPE_SAT_EN
  // Clamp towards the sign of a, which is also the sign of both operands here.
  assign res_sum = !ovf  ? full_sum :
                   a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                           {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_sum = full_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < STAGES; j++) begin
        valid_q[j] <= 1'b0;
        a_q[j]     <= '0;
        bx_q[j]    <= '0;
        sum_q[j]   <= '0;
        carry_q[j] <= 1'b0;
        tag_q[j]   <= '0;
      end
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      tag_out_r   <= '0;
    end else if (adv) begin
      valid_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        a_q[0]     <= bus.a;
        bx_q[0]    <= in_bx;
        sum_q[0]   <= '0;
        carry_q[0] <= in_cin;
        tag_q[0]   <= bus.tag_in;
      end
      for (int j = 1; j < STAGES; j++) begin
        valid_q[j] <= valid_q[j-1];
        a_q[j]     <= a_q[j-1];
        bx_q[j]    <= bx_q[j-1];
        sum_q[j]   <= stage_sum[j-1];
        carry_q[j] <= chunk_res[j-1][CW];
        tag_q[j]   <= tag_q[j-1];
      end
      out_valid_r <= valid_q[STAGES-1];
      sum_r       <= res_sum;
      carry_out_r <= raw_cout;
      overflow_r  <= ovf;
      zero_r      <= (res_sum == '0);
      tag_out_r   <= tag_q[STAGES-1];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
  assign bus.tag_out   = tag_out_r;
endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: a 4-stage instance under backpressure plus
// 1-stage and 32-stage instances fed the same accepted operations.
module tb_add_pipe;
  localparam int W  = 32;
  localparam int TW = 4;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  s;
    logic [W-1:0]  s_sat;
    logic          cout;
    logic          ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stream_mode = 0;

  exp_t q_main[$];
  exp_t q_one[$];
  exp_t q_wide[$];
  exp_t e_main, e_one, e_wide;

  vec_t dir_vecs [8];
  vec_t str_vecs [8];

  add_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus   ();
  add_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus1  ();
  add_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus32 ();

  add_pipe #(.WIDTH(W), .STAGES(4),  .TAG_W(TW)) dut      (.clk(clk), .rst_n(rst_n), .bus(bus));
  add_pipe #(.WIDTH(W), .STAGES(1),  .TAG_W(TW)) dut_one  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  add_pipe #(.WIDTH(W), .STAGES(32), .TAG_W(TW)) dut_wide (.clk(clk), .rst_n(rst_n), .bus(bus32));

  // The side instances see exactly the operations the main instance accepts.
  assign bus1.in_valid   = bus.in_valid && bus.in_ready;
  assign bus1.a          = bus.a;
  assign bus1.b          = bus.b;
  assign bus1.carry_in   = bus.carry_in;
  assign bus1.sub        = bus.sub;
  assign bus1.tag_in     = bus.tag_in;
  assign bus1.out_ready  = 1'b1;
  assign bus32.in_valid  = bus.in_valid && bus.in_ready;
  assign bus32.a         = bus.a;
  assign bus32.b         = bus.b;
  assign bus32.carry_in  = bus.carry_in;
  assign bus32.sub       = bus.sub;
  assign bus32.tag_in    = bus.tag_in;
  assign bus32.out_ready = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : ready_gen
    logic [3:0] pat;
    int pidx;
    pat = 4'b1001;
    pidx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stream_mode) begin
        bus.out_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  function automatic vec_t mkVec(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input logic [TW-1:0] tag,
                                 input logic [W-1:0] s, input logic [W-1:0] s_sat,
                                 input logic cout, input logic ovf);
    mkVec.a = a; mkVec.b = b; mkVec.cin = cin; mkVec.sub = sub; mkVec.tag = tag;
    mkVec.s = s; mkVec.s_sat = s_sat; mkVec.cout = cout; mkVec.ovf = ovf;
  endfunction

  task automatic checkValue(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string who, input int stages, input bit lat, input exp_t e,
                             input logic [W-1:0] s, input logic co, input logic ov,
                             input logic z, input logic [TW-1:0] t);
    checkValue({who, " sum"}, s, e.sum);
    checkValue({who, " carry_out"}, {31'b0, co}, {31'b0, e.cout});
    checkValue({who, " overflow"}, {31'b0, ov}, {31'b0, e.ovf});
    checkValue({who, " zero"}, {31'b0, z}, {31'b0, e.zero});
    checkValue({who, " tag_out"}, {28'b0, t}, {28'b0, e.tag});
    if (lat) checkValue({who, " latency"}, cyc - (e.acc + 1), stages);
  endtask

  task automatic applyStimulus(input vec_t v, input bit lat);
    exp_t e;
    int tries;
    bit done;
    tries = 0;
    done = 0;
    @(negedge clk);
    bus.a = v.a;
    bus.b = v.b;
    bus.carry_in = v.cin;
    bus.sub = v.sub;
    bus.tag_in = v.tag;
    bus.in_valid = 1'b1;
    while (!done) begin
      if (bus.in_ready) begin
        e.acc = cyc;
        @(posedge clk);
`ifdef ADD_PIPE_SAT_EN
        e.sum = v.s_sat;
`else
        e.sum = v.s;
`endif
        e.cout = v.cout;
        e.ovf  = v.ovf;
        e.zero = (e.sum == '0);
        e.tag  = v.tag;
        e.lat  = lat;
        q_main.push_back(e);
        q_one.push_back(e);
        q_wide.push_back(e);
        done = 1;
      end else if (tries > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept timeout: tag %h not accepted, expected accept within 200 cycles", v.tag);
        bus.in_valid = 1'b0;
        done = 1;
      end else begin
        tries++;
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic applyIdle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((q_main.size() + q_one.size() + q_wide.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkValue("drain pending results", q_main.size() + q_one.size() + q_wide.size(), 0);
  endtask

  task automatic checkResetOutputs(input string who);
    checkValue({who, " out_valid"}, {31'b0, bus.out_valid}, 0);
    checkValue({who, " sum"}, bus.sum, 0);
    checkValue({who, " carry_out"}, {31'b0, bus.carry_out}, 0);
    checkValue({who, " overflow"}, {31'b0, bus.overflow}, 0);
    checkValue({who, " zero"}, {31'b0, bus.zero}, 0);
    checkValue({who, " tag_out"}, {28'b0, bus.tag_out}, 0);
    checkValue({who, " in_ready"}, {31'b0, bus.in_ready}, 1);
    checkValue({who, " out_valid s1"}, {31'b0, bus1.out_valid}, 0);
    checkValue({who, " out_valid s32"}, {31'b0, bus32.out_valid}, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkValue("in_ready vs adv", {31'b0, bus.in_ready}, {31'b0, (!bus.out_valid || bus.out_ready)});
      if (bus.out_valid && bus.out_ready) begin
        if (q_main.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL main extra result: tag %h presented, expected none", bus.tag_out);
        end else begin
          e_main = q_main.pop_front();
          checkOutput("main", 4, e_main.lat, e_main, bus.sum, bus.carry_out, bus.overflow, bus.zero, bus.tag_out);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus1.out_valid) begin
      if (q_one.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL s1 extra result: tag %h presented, expected none", bus1.tag_out);
      end else begin
        e_one = q_one.pop_front();
        checkOutput("s1", 1, 1'b1, e_one, bus1.sum, bus1.carry_out, bus1.overflow, bus1.zero, bus1.tag_out);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus32.out_valid) begin
      if (q_wide.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL s32 extra result: tag %h presented, expected none", bus32.tag_out);
      end else begin
        e_wide = q_wide.pop_front();
        checkOutput("s32", 32, 1'b1, e_wide, bus32.sum, bus32.carry_out, bus32.overflow, bus32.zero, bus32.tag_out);
      end
    end
  end

  initial begin
    dir_vecs[0] = mkVec(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd8,  32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1);
    dir_vecs[1] = mkVec(32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 4'd9,  32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1);
    dir_vecs[2] = mkVec(32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'd10, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0);
    dir_vecs[3] = mkVec(32'h00001234, 32'h00001234, 1'b0, 1'b1, 4'd11, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    dir_vecs[4] = mkVec(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'd12, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    dir_vecs[5] = mkVec(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 4'd13, 32'h00000006, 32'h00000006, 1'b1, 1'b0);
    dir_vecs[6] = mkVec(32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'd14, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1);
    dir_vecs[7] = mkVec(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 4'd15, 32'h01000101, 32'h01000101, 1'b0, 1'b0);

    str_vecs[0] = mkVec(32'h00000001, 32'h00000002, 1'b0, 1'b0, 4'd0, 32'h00000003, 32'h00000003, 1'b0, 1'b0);
    str_vecs[1] = mkVec(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 4'd1, 32'h00010000, 32'h00010000, 1'b0, 1'b0);
    str_vecs[2] = mkVec(32'h12345678, 32'h11111111, 1'b0, 1'b0, 4'd2, 32'h23456789, 32'h23456789, 1'b0, 1'b0);
    str_vecs[3] = mkVec(32'h00000100, 32'h00000001, 1'b0, 1'b1, 4'd3, 32'h000000FF, 32'h000000FF, 1'b1, 1'b0);
    str_vecs[4] = mkVec(32'hFFFF0000, 32'h00010000, 1'b0, 1'b0, 4'd4, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    str_vecs[5] = mkVec(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 4'd5, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    str_vecs[6] = mkVec(32'h00000000, 32'h00000001, 1'b0, 1'b1, 4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    str_vecs[7] = mkVec(32'h40000000, 32'h40000000, 1'b0, 1'b0, 4'd7, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1);

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.carry_in = 1'b0;
    bus.sub = 1'b0;
    bus.tag_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    foreach (dir_vecs[i]) applyStimulus(dir_vecs[i], 1'b1);
    applyIdle();
    waitDrain();

    $display("[TB] back-to-back stream under backpressure");
    stream_mode = 1;
    foreach (str_vecs[i]) applyStimulus(str_vecs[i], 1'b0);
    applyIdle();
    waitDrain();
    stream_mode = 0;
    repeat (2) @(posedge clk);

    $display("[TB] reset with operations in flight");
    for (int i = 0; i < 3; i++) applyStimulus(dir_vecs[i], 1'b1);
    applyIdle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q_main.delete();
    q_one.delete();
    q_wide.delete();
    #1;
    checkResetOutputs("mid-flight reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkValue("in_ready after release", {31'b0, bus.in_ready}, 1);
    applyStimulus(dir_vecs[3], 1'b1);
    applyIdle();
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
